ps2_scancode_display: RTL

PS2_SCANCODE_DISPLAY -- requirements
Module: ps2_scancode_display

---
 rtl/ps2_scancode_display_pkg.sv | 17 +
 rtl/ps2_scancode_display_scancode_to_segment.sv | 41 ++++
 rtl/ps2_scancode_display.sv | 81 ++++++++
 3 files changed

// File: rtl/ps2_scancode_display_pkg.sv
// Shared constants and parser-state encoding for the PS/2 scan-code display.
package ps2_scancode_display_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] BKSP_CODE  = 8'h66;
  localparam logic [7:0] ESC_CODE   = 8'h76;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } ps2_state_e;

endpackage

// File: rtl/ps2_scancode_display_scancode_to_segment.sv
// Combinational scan-code (set 2) to active-low gfedcba segment pattern lookup.
module scancode_to_segment
  import ps2_scancode_display_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [6:0] seg_o,
  output logic       valid_o
);

  always_comb begin
    seg_o   = SEG_BLANK;
    valid_o = 1'b1;
    unique case (byte_i)
      8'h45: seg_o = 7'h40; // 0
      8'h16: seg_o = 7'h79;
      8'h1E: seg_o = 7'h24;
      8'h26: seg_o = 7'h30;
      8'h25: seg_o = 7'h19;
      8'h2E: seg_o = 7'h12;
      8'h36: seg_o = 7'h02;
      8'h3D: seg_o = 7'h78;
      8'h3E: seg_o = 7'h00;
      8'h46: seg_o = 7'h10; // 9
      8'h1C: seg_o = 7'h08; // A
      8'h32: seg_o = 7'h03;
      8'h21: seg_o = 7'h46;
      8'h23: seg_o = 7'h21;
      8'h24: seg_o = 7'h06;
      8'h2B: seg_o = 7'h0E;
      8'h33: seg_o = 7'h09;
      8'h4B: seg_o = 7'h47;
      8'h31: seg_o = 7'h2B;
      8'h44: seg_o = 7'h23;
      8'h4D: seg_o = 7'h0C;
      8'h2C: seg_o = 7'h07;
      8'h3C: seg_o = 7'h41; // U
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_scancode_display.sv
// PS/2 make/break parser driving a left-shifting seven-segment character buffer.
module ps2_scancode_display
  import ps2_scancode_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              ps2_byte,
  input  logic                    ps2_byte_en,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] seg_display,
  output logic [CNT_W-1:0]        char_count
);

  ps2_state_e                      state_q, state_d;
  logic [NUM_DIGITS-1:0][6:0]      digits_q, digits_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [6:0]                      dec_seg;
  logic                            dec_valid;

  scancode_to_segment u_dec (
    .byte_i  (ps2_byte),
    .seg_o   (dec_seg),
    .valid_o (dec_valid)
  );

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    cnt_d    = cnt_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = SEG_BLANK;
    end else if (ps2_byte_en) begin
      unique case (state_q)
        IDLE: begin
          if (ps2_byte == BREAK_CODE) begin
            state_d = BRK;
          end else if (ps2_byte == EXT_CODE) begin
            state_d = EXT;
          end else if (ps2_byte == ESC_CODE) begin
            cnt_d = '0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_d[i] = SEG_BLANK;
          end else if (ps2_byte == BKSP_CODE) begin
            if (cnt_q != '0) begin
              for (int i = 0; i < NUM_DIGITS - 1; i++) digits_d[i] = digits_q[i+1];
              digits_d[NUM_DIGITS-1] = SEG_BLANK;
              cnt_d = cnt_q - CNT_W'(1);
            end
          end else if (dec_valid) begin
            // Oldest character falls off the left edge; count saturates.
            for (int i = 1; i < NUM_DIGITS; i++) digits_d[i] = digits_q[i-1];
            digits_d[0] = dec_seg;
            if (cnt_q != CNT_W'(NUM_DIGITS)) cnt_d = cnt_q + CNT_W'(1);
          end
        end
        EXT:     state_d = (ps2_byte == BREAK_CODE) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) digits_q[i] <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
    end
  end

  assign seg_display = digits_q;
  assign char_count  = cnt_q;

endmodule
